// File: rtl/cust_afu_host_buf_queue.sv
// Multi-channel host-buffer-address queue: per-channel FIFOs drained round-robin into one registered valid/ready output.
// Optional feature macro: CUST_AFU_HBQ_STATS_EN adds saturating per-channel push/drop counters.
module cust_afu_host_buf_queue #(
  parameter int  BE_CH = 8,
  parameter int  DEPTH = 4,
  parameter int  AW    = 64,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int CHW   = (BE_CH > 1) ? $clog2(BE_CH) : 1
) (
  input  logic              axi4_mm_clk,
  input  logic              axi4_mm_rst_n,
  input  logic              enable,
  input  logic [BE_CH-1:0]  push_valid,
  input  logic [AW-1:0]     push_addr [BE_CH-1:0],
  output logic [BE_CH-1:0]  push_ready,
  input  logic [BE_CH-1:0]  flush,
  output logic              pop_valid,
  input  logic              pop_ready,
  output logic [AW-1:0]     pop_addr,
  output logic [CHW-1:0]    pop_ch,
  output logic [CW-1:0]     occupancy [BE_CH-1:0],
  output logic [BE_CH-1:0]  overflow
`ifdef CUST_AFU_HBQ_STATS_EN
  ,
  output logic [31:0]       push_cnt [BE_CH-1:0],
  output logic [31:0]       drop_cnt [BE_CH-1:0]
`endif
);

  localparam int AIW = CW - 1;

  logic [CW-1:0]    r_wr_ptr [BE_CH-1:0];
  logic [CW-1:0]    r_rd_ptr [BE_CH-1:0];
  logic [AW-1:0]    r_mem    [BE_CH-1:0][DEPTH-1:0];
  logic [BE_CH-1:0] r_overflow;
  logic             r_pop_valid;
  logic [AW-1:0]    r_pop_addr;
  logic [CHW-1:0]   r_pop_ch;
  logic [CHW-1:0]   r_rr;

  logic [BE_CH-1:0] w_full;
  logic [BE_CH-1:0] w_empty;
  logic [BE_CH-1:0] w_avail;
  logic [BE_CH-1:0] w_push_acc;
  logic [BE_CH-1:0] w_push_drop;
  logic [CHW-1:0]   w_grant;
  logic             w_found;
  logic             w_load;
  int               w_idx;

  // A channel being flushed is neither pushed into nor granted this cycle.
  always_comb begin
    w_full      = '0;
    w_empty     = '0;
    w_avail     = '0;
    w_push_acc  = '0;
    w_push_drop = '0;
    for (int i = 0; i < BE_CH; i++) begin
      w_empty[i]     = (r_wr_ptr[i] == r_rd_ptr[i]);
      w_full[i]      = (r_wr_ptr[i][CW-1] != r_rd_ptr[i][CW-1]) &&
                       (r_wr_ptr[i][AIW-1:0] == r_rd_ptr[i][AIW-1:0]);
      w_avail[i]     = !w_empty[i] && !flush[i];
      w_push_acc[i]  = push_valid[i] && !w_full[i] && !flush[i];
      w_push_drop[i] = push_valid[i] &&  w_full[i] && !flush[i];
      occupancy[i]   = r_wr_ptr[i] - r_rd_ptr[i];
    end
  end

  assign push_ready = ~w_full;

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= BE_CH; k++) begin
      w_idx = (int'(r_rr) + k) % BE_CH;
      if (!w_found && w_avail[w_idx]) begin
        w_grant = CHW'(w_idx);
        w_found = 1'b1;
      end
    end
  end

  assign w_load = enable && (!r_pop_valid || pop_ready) && w_found;

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      for (int i = 0; i < BE_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
      end
      r_overflow <= '0;
    end else begin
      for (int i = 0; i < BE_CH; i++) begin
        if (flush[i]) begin
          r_wr_ptr[i]   <= '0;
          r_rd_ptr[i]   <= '0;
          r_overflow[i] <= 1'b0;
        end else begin
          if (w_push_acc[i])
            r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
          if (w_push_drop[i])
            r_overflow[i] <= 1'b1;
          if (w_load && (w_grant == CHW'(i)))
            r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge axi4_mm_clk) begin
    for (int i = 0; i < BE_CH; i++) begin
      if (w_push_acc[i])
        r_mem[i][r_wr_ptr[i][AIW-1:0]] <= push_addr[i];
    end
  end

  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      r_pop_valid <= 1'b0;
      r_pop_addr  <= '0;
      r_pop_ch    <= '0;
      r_rr        <= CHW'(BE_CH - 1);
    end else if (w_load) begin
      r_pop_valid <= 1'b1;
      r_pop_addr  <= r_mem[w_grant][r_rd_ptr[w_grant][AIW-1:0]];
      r_pop_ch    <= w_grant;
      r_rr        <= w_grant;
    end else if (r_pop_valid && pop_ready) begin
      r_pop_valid <= 1'b0;
    end
  end

  assign pop_valid = r_pop_valid;
  assign pop_addr  = r_pop_addr;
  assign pop_ch    = r_pop_ch;
  assign overflow  = r_overflow;

`ifdef CUST_AFU_HBQ_STATS_EN
  logic [31:0] r_push_cnt [BE_CH-1:0];
  logic [31:0] r_drop_cnt [BE_CH-1:0];

  // Counters saturate and survive flush; only reset clears them.
  always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
    if (!axi4_mm_rst_n) begin
      for (int i = 0; i < BE_CH; i++) begin
        r_push_cnt[i] <= '0;
        r_drop_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < BE_CH; i++) begin
        if (w_push_acc[i] && (r_push_cnt[i] != 32'hFFFF_FFFF))
          r_push_cnt[i] <= r_push_cnt[i] + 32'd1;
        if (w_push_drop[i] && (r_drop_cnt[i] != 32'hFFFF_FFFF))
          r_drop_cnt[i] <= r_drop_cnt[i] + 32'd1;
      end
    end
  end

  assign push_cnt = r_push_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_cust_afu_host_buf_queue.sv
// Self-checking bench for cust_afu_host_buf_queue: directed vector table, hand-written corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_cust_afu_host_buf_queue;

  localparam int BE_CH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 64;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int CHW   = $clog2(BE_CH);

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [BE_CH-1:0]  push_valid;
  logic [AW-1:0]     push_addr [BE_CH-1:0];
  logic [BE_CH-1:0]  push_ready;
  logic [BE_CH-1:0]  flush;
  logic              pop_valid;
  logic              pop_ready;
  logic [AW-1:0]     pop_addr;
  logic [CHW-1:0]    pop_ch;
  logic [CW-1:0]     occupancy [BE_CH-1:0];
  logic [BE_CH-1:0]  overflow;
`ifdef CUST_AFU_HBQ_STATS_EN
  logic [31:0]       push_cnt [BE_CH-1:0];
  logic [31:0]       drop_cnt [BE_CH-1:0];
`endif

  int nVec = 0;
  int nMis = 0;

  cust_afu_host_buf_queue #(.BE_CH(BE_CH), .DEPTH(DEPTH), .AW(AW)) dut (
    .axi4_mm_clk   (clk),
    .axi4_mm_rst_n (rst_n),
    .enable        (enable),
    .push_valid    (push_valid),
    .push_addr     (push_addr),
    .push_ready    (push_ready),
    .flush         (flush),
    .pop_valid     (pop_valid),
    .pop_ready     (pop_ready),
    .pop_addr      (pop_addr),
    .pop_ch        (pop_ch),
    .occupancy     (occupancy),
    .overflow      (overflow)
`ifdef CUST_AFU_HBQ_STATS_EN
    ,
    .push_cnt      (push_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queues per channel plus the output slot.
  logic [AW-1:0]    mq [BE_CH][$];
  bit               mValid;
  logic [AW-1:0]    mAddr;
  int               mCh;
  int               mRr;
  bit [BE_CH-1:0]   mOvf;
  int unsigned      mPush [BE_CH];
  int unsigned      mDrop [BE_CH];

  typedef struct {
    logic [7:0]  pv;
    logic [63:0] base;
    logic [7:0]  fl;
    logic        pr;
    logic        en;
    logic        expValid;
    logic [2:0]  expCh;
    logic [63:0] expAddr;
    int          occCh;
    logic [2:0]  expOcc;
    logic [7:0]  expOvf;
  } vec_t;

  vec_t tbl [14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < BE_CH; i++) begin
      mq[i].delete();
      mPush[i] = 0;
      mDrop[i] = 0;
    end
    mValid = 1'b0;
    mAddr  = '0;
    mCh    = 0;
    mRr    = BE_CH - 1;
    mOvf   = '0;
  endtask

  task automatic modelStep(input logic [7:0] pv, input logic [63:0] base, input logic [7:0] fl,
                           input logic pr, input logic en);
    bit fullSnap [BE_CH];
    int g;
    g = -1;
    for (int i = 0; i < BE_CH; i++) fullSnap[i] = (mq[i].size() == DEPTH);
    for (int k = 1; k <= BE_CH; k++) begin
      int c;
      c = (mRr + k) % BE_CH;
      if (g < 0 && mq[c].size() > 0 && !fl[c]) g = c;
    end
    if (en && (!mValid || pr) && g >= 0) begin
      mAddr  = mq[g].pop_front();
      mValid = 1'b1;
      mCh    = g;
      mRr    = g;
    end else if (mValid && pr) begin
      mValid = 1'b0;
    end
    for (int i = 0; i < BE_CH; i++) begin
      if (fl[i]) begin
        mq[i].delete();
        mOvf[i] = 1'b0;
      end else if (pv[i]) begin
        if (fullSnap[i]) begin
          mOvf[i] = 1'b1;
          if (mDrop[i] != 32'hFFFF_FFFF) mDrop[i]++;
        end else begin
          mq[i].push_back(base + 64'(i));
          if (mPush[i] != 32'hFFFF_FFFF) mPush[i]++;
        end
      end
    end
  endtask

  task automatic compareModel();
    logic [BE_CH-1:0] er;
    for (int i = 0; i < BE_CH; i++) er[i] = (mq[i].size() != DEPTH);
    checkOutput("pop_valid", 64'(pop_valid), 64'(mValid));
    checkOutput("pop_addr", pop_addr, mAddr);
    checkOutput("pop_ch", 64'(pop_ch), 64'(mCh));
    checkOutput("push_ready", 64'(push_ready), 64'(er));
    checkOutput("overflow", 64'(overflow), 64'(mOvf));
    for (int i = 0; i < BE_CH; i++) begin
      checkOutput($sformatf("occupancy[%0d]", i), 64'(occupancy[i]), 64'(mq[i].size()));
`ifdef CUST_AFU_HBQ_STATS_EN
      checkOutput($sformatf("push_cnt[%0d]", i), 64'(push_cnt[i]), 64'(mPush[i]));
      checkOutput($sformatf("drop_cnt[%0d]", i), 64'(drop_cnt[i]), 64'(mDrop[i]));
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare just after it.
  task automatic applyStimulus(input logic [7:0] pv, input logic [63:0] base, input logic [7:0] fl,
                               input logic pr, input logic en);
    push_valid = pv;
    for (int i = 0; i < BE_CH; i++) push_addr[i] = base + 64'(i);
    flush      = fl;
    pop_ready  = pr;
    enable     = en;
    @(posedge clk);
    modelStep(pv, base, fl, pr, en);
    #1;
    compareModel();
  endtask

  task automatic midReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("midrst_pop_valid", 64'(pop_valid), 64'h0);
    checkOutput("midrst_push_ready", 64'(push_ready), 64'hFF);
    compareModel();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b1;
    enable     = 1'b0;
    push_valid = '0;
    flush      = '0;
    pop_ready  = 1'b0;
    for (int i = 0; i < BE_CH; i++) push_addr[i] = '0;
    #1 rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput("rst_pop_valid", 64'(pop_valid), 64'h0);
    checkOutput("rst_pop_addr", pop_addr, 64'h0);
    checkOutput("rst_pop_ch", 64'(pop_ch), 64'h0);
    checkOutput("rst_push_ready", 64'(push_ready), 64'hFF);
    checkOutput("rst_overflow", 64'(overflow), 64'h0);
    compareModel();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: single push latency, round-robin over chs 1/3/5, push+flush on ch4.
    tbl[0]  = '{8'h04, 64'hFFE, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0,    2, 3'd1, 8'h00};
    tbl[1]  = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 64'h1000, 2, 3'd0, 8'h00};
    tbl[2]  = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 64'h1000, 2, 3'd0, 8'h00};
    tbl[3]  = '{8'h2A, 64'hA10, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 64'h1000, 1, 3'd1, 8'h00};
    tbl[4]  = '{8'h2A, 64'hA20, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 64'h1000, 3, 3'd2, 8'h00};
    tbl[5]  = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 64'hA13,  3, 3'd1, 8'h00};
    tbl[6]  = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 64'hA15,  5, 3'd1, 8'h00};
    tbl[7]  = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 64'hA11,  1, 3'd1, 8'h00};
    tbl[8]  = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b1, 3'd3, 64'hA23,  3, 3'd0, 8'h00};
    tbl[9]  = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 64'hA25,  5, 3'd0, 8'h00};
    tbl[10] = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b1, 3'd1, 64'hA21,  1, 3'd0, 8'h00};
    tbl[11] = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 64'hA21,  1, 3'd0, 8'h00};
    tbl[12] = '{8'h10, 64'hBEE0,8'h10, 1'b1, 1'b1, 1'b0, 3'd1, 64'hA21,  4, 3'd0, 8'h00};
    tbl[13] = '{8'h00, 64'h0,   8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 64'hA21,  4, 3'd0, 8'h00};

    for (int v = 0; v < 14; v++) begin
      applyStimulus(tbl[v].pv, tbl[v].base, tbl[v].fl, tbl[v].pr, tbl[v].en);
      checkOutput($sformatf("tbl%0d_valid", v), 64'(pop_valid), 64'(tbl[v].expValid));
      checkOutput($sformatf("tbl%0d_ch", v), 64'(pop_ch), 64'(tbl[v].expCh));
      checkOutput($sformatf("tbl%0d_addr", v), pop_addr, tbl[v].expAddr);
      checkOutput($sformatf("tbl%0d_occ", v), 64'(occupancy[tbl[v].occCh]), 64'(tbl[v].expOcc));
      checkOutput($sformatf("tbl%0d_ovf", v), 64'(overflow), 64'(tbl[v].expOvf));
    end

    // Fill ch0, overflow it, drain to confirm contents survived, then flush clears the sticky bit.
    for (int k = 0; k < 4; k++) applyStimulus(8'h01, 64'hC0 + 64'(k), 8'h00, 1'b0, 1'b0);
    checkOutput("fill_ready0", 64'(push_ready[0]), 64'h0);
    checkOutput("fill_occ0", 64'(occupancy[0]), 64'h4);
    applyStimulus(8'h01, 64'hC4, 8'h00, 1'b0, 1'b0);
    checkOutput("ovf_set0", 64'(overflow[0]), 64'h1);
    checkOutput("ovf_occ0", 64'(occupancy[0]), 64'h4);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(8'h00, 64'h0, 8'h00, 1'b1, 1'b1);
      checkOutput($sformatf("drain%0d_valid", k), 64'(pop_valid), 64'h1);
      checkOutput($sformatf("drain%0d_ch", k), 64'(pop_ch), 64'h0);
      checkOutput($sformatf("drain%0d_addr", k), pop_addr, 64'hC0 + 64'(k));
    end
    applyStimulus(8'h00, 64'h0, 8'h00, 1'b1, 1'b1);
    checkOutput("drain_done", 64'(pop_valid), 64'h0);
    checkOutput("ovf_sticky0", 64'(overflow[0]), 64'h1);
    applyStimulus(8'h00, 64'h0, 8'h01, 1'b1, 1'b1);
    checkOutput("flush_ovf0", 64'(overflow[0]), 64'h0);
    checkOutput("flush_occ0", 64'(occupancy[0]), 64'h0);

    // Hold the output under backpressure while other channels fill, then check round-robin resumes.
    applyStimulus(8'h44, 64'hD0, 8'h00, 1'b0, 1'b1);
    applyStimulus(8'h00, 64'h0, 8'h00, 1'b0, 1'b1);
    checkOutput("hold_first_ch", 64'(pop_ch), 64'h2);
    for (int k = 0; k < 5; k++) begin
      applyStimulus((k < 3) ? 8'h0A : 8'h00, 64'hE0 + 64'(k), 8'h00, 1'b0, 1'b1);
      checkOutput($sformatf("hold%0d_valid", k), 64'(pop_valid), 64'h1);
      checkOutput($sformatf("hold%0d_ch", k), 64'(pop_ch), 64'h2);
      checkOutput($sformatf("hold%0d_addr", k), pop_addr, 64'hD2);
    end
    applyStimulus(8'h00, 64'h0, 8'h00, 1'b1, 1'b1);
    checkOutput("rel0_ch", 64'(pop_ch), 64'h3);
    checkOutput("rel0_addr", pop_addr, 64'hE3);
    applyStimulus(8'h00, 64'h0, 8'h00, 1'b1, 1'b1);
    checkOutput("rel1_ch", 64'(pop_ch), 64'h6);
    checkOutput("rel1_addr", pop_addr, 64'hD6);
    applyStimulus(8'h00, 64'h0, 8'h00, 1'b1, 1'b1);
    checkOutput("rel2_ch", 64'(pop_ch), 64'h1);
    checkOutput("rel2_addr", pop_addr, 64'hE1);
    for (int k = 0; k < 7; k++) applyStimulus(8'h00, 64'h0, 8'h00, 1'b1, 1'b1);
    checkOutput("rel_drained", 64'(pop_valid), 64'h0);

`ifdef CUST_AFU_HBQ_STATS_EN
    // Six pushes into ch7 with no pops: four land, two drop; flush leaves the counters alone.
    for (int k = 0; k < 6; k++) applyStimulus(8'h80, 64'hF0 + 64'(k), 8'h00, 1'b0, 1'b0);
    checkOutput("stats_push7", 64'(push_cnt[7]), 64'd4);
    checkOutput("stats_drop7", 64'(drop_cnt[7]), 64'd2);
    applyStimulus(8'h00, 64'h0, 8'h80, 1'b0, 1'b0);
    checkOutput("stats_flush_push7", 64'(push_cnt[7]), 64'd4);
    checkOutput("stats_flush_drop7", 64'(drop_cnt[7]), 64'd2);
    checkOutput("stats_flush_occ7", 64'(occupancy[7]), 64'd0);
`endif

    // Randomized traffic with a mid-run asynchronous reset.
    for (int n = 0; n < 2500; n++) begin
      logic [7:0]  pv;
      logic [7:0]  fl;
      logic [63:0] base;
      if (n == 1200) midReset();
      pv   = (n % 400 < 200) ? 8'($urandom & $urandom & $urandom) : 8'($urandom & $urandom);
      fl   = ($urandom_range(0, 15) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      base = {$urandom, $urandom};
      applyStimulus(pv, base, fl, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
